agc_level_monitor: RTL and testbench
====================================

# agc_level_monitor

Downstream companion to `agc_top`. Consumes the AGC's 16-bit signed Q8.8 I/Q output and computes block-averaged instantaneous power over fixed windows of 2^WIN_LOG2 valid samples. It also runs a lock-detect state machine that reports whether the AGC output level has settled inside a target power band. Outputs feed the status/CSR logic and any downstream demodulator that must wait for a stable level.

## Interface
- `WIN_LOG2`, 4: log2 of window length in valid samples (window = 16).
- `LO_TH`, 32'h0000_C000: lower in-band bound on mean power, unsigned Q16.16 (0.75).
- `HI_TH`, 32'h0001_4000: upper in-band bound on mean power, unsigned Q16.16 (1.25).
- `LOCK_CNT`, 3: consecutive in-band windows required to declare lock (≥1).
- `UNLOCK_CNT`, 2: consecutive out-of-band windows required to drop lock (≥1).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `clr` in 1: synchronous flush of window state (pipeline, accumulator, sample count). The FSM is not affected.
- `in_valid` in 1: the sample on `z_i_in`/`z_q_in` is accepted this cycle.
- `z_i_in` in 16 signed: AGC I output, Q8.8.
- `z_q_in` in 16 signed: AGC Q output, Q8.8.
- `pwr_out` out 32 unsigned: mean power of the last completed window, Q16.16.
- `pwr_valid` out 1: one-cycle pulse when `pwr_out` updates.
- `over` out 1: last window mean > HI_TH.
- `under` out 1: last window mean < LO_TH.
- `lock_state` out 2: FSM state.
- `locked` out 1: high in LOCKED or HOLD.

## Operation
- Stage 1: on the edge E where `in_valid`=1, register p = i·i + q·q and set `p_vld`=1.
  - Each square is ≤2^30, so p ≤2^31 and fits in 32 unsigned bits (Q16.16).
  - On any edge with `in_valid`=0, `p_vld`←0.
- Stage 2: on an edge with `p_vld`=1, do `acc += p` and `cnt += 1`.
  - `acc` is 32+WIN_LOG2 bits and never overflows, so no saturation is needed.
  - When `cnt` = 2^WIN_LOG2−1 before the increment (window complete):
    - `pwr_out` ← (acc+p) >> WIN_LOG2, truncated.
    - `pwr_valid` ← 1.
    - `over` and `under` update.
    - `acc` ← 0 and `cnt` ← 0.
    - The FSM steps once using the new mean.
- In-band means LO_TH ≤ mean ≤ HI_TH. Out-of-band is anything else.
- FSM states: SEARCH=2'b00, ACQ=2'b01, LOCKED=2'b10, HOLD=2'b11. It evaluates only on window completion. `gcnt` and `bcnt` are internal run counters.
  - SEARCH:
    - In-band: if LOCK_CNT=1 → LOCKED; else → ACQ with gcnt=1.
    - Out-of-band: stay in SEARCH.
  - ACQ:
    - In-band: gcnt+1. On reaching LOCK_CNT → LOCKED, gcnt=0.
    - Out-of-band: → SEARCH, gcnt=0.
  - LOCKED:
    - Out-of-band: if UNLOCK_CNT=1 → SEARCH; else → HOLD with bcnt=1.
    - In-band: stay in LOCKED.
  - HOLD:
    - In-band: → LOCKED, bcnt=0.
    - Out-of-band: bcnt+1. On reaching UNLOCK_CNT → SEARCH, bcnt=0.
- `clr`=1 zeroes `p_vld`, `acc` and `cnt`. The sample presented in the same cycle is dropped, and a window completing that cycle is discarded (no `pwr_valid`). `pwr_out`, `over`, `under` and the FSM keep their values.
- Gaps in `in_valid` only stall the window; the window always counts valid samples, not cycles.

## Timing
- Reset (`rst`=0 at an edge) sets:
  - `pwr_out`=0, `pwr_valid`=0, `over`=0, `under`=0.
  - `lock_state`=SEARCH, `locked`=0.
  - `acc`=0, `cnt`=0, `p_vld`=0, gcnt=bcnt=0.
- Reset has priority over `clr` and `in_valid`. Reset mid-window discards the partial window.
- Latency: the last sample of a window is accepted at edge E. `pwr_valid` is high for exactly the cycle after edge E+1. `pwr_out`, `over`, `under`, `lock_state` and `locked` all change at E+1, together.
- `pwr_valid` is never high on two consecutive cycles when WIN_LOG2 ≥1.
- With `in_valid` continuously high, there is one `pwr_valid` pulse every 2^WIN_LOG2 cycles.
- Throughput is one sample per clock with no backpressure.

## Test plan
- Lock acquisition:
  - Stimulus: reset, then 48 continuous samples of I=16'h0100, Q=0.
  - Response: three `pwr_valid` pulses with `pwr_out`=32'h0001_0000; states ACQ → ACQ → LOCKED; `locked`=1 two cycles after the 48th sample edge.
- Unlock:
  - Stimulus: from LOCKED, 32 samples of I=16'h0200, Q=0.
  - Response: `pwr_out`=32'h0004_0000 and `over`=1; HOLD after window 1, SEARCH after window 2; `locked` falls after window 2.
- Recovery from HOLD:
  - Stimulus: from LOCKED, one window at I=16'h0080 (mean 32'h0000_4000), then one window at 1.0.
  - Response: first window gives `under`=1 and HOLD; second window returns to LOCKED; `locked` stays 1 throughout.
- Extreme values with gaps:
  - Stimulus: 16 samples of I=Q=16'h8000, delivered with `in_valid` toggling 1/0.
  - Response: exactly one `pwr_valid`, 2 cycles after the 16th valid edge, with `pwr_out`=32'h8000_0000 and `over`=1 (no wrap).
- Reset and clear mid-window:
  - Stimulus: 10 samples, then `rst`=0 for one cycle, then 16 samples of 1.0.
  - Response: one `pwr_valid`, after the 16th post-reset sample only, with `pwr_out`=32'h0001_0000.
  - Stimulus: repeat with `clr`=1 asserted together with the 16th sample.
  - Response: no `pwr_valid`, and the FSM is unchanged.

Source files
------------

// File: rtl/agc_level_monitor.sv
// -----------------------------------------------------------------------------
// agc_level_monitor
//
// Block-averaged power meter and lock detector for the AGC output.
//
// Each accepted I/Q sample (signed Q8.8) is squared and summed into an
// instantaneous power p (unsigned Q16.16). The powers of 2^WIN_LOG2 accepted
// samples are averaged into pwr_out. Each completed window is classified as
// in-band (LO_TH <= mean <= HI_TH) or out-of-band, and that result steps a
// four-state lock FSM.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   clr         synchronous flush of the window (pipeline, accumulator, count)
//   in_valid    z_i_in / z_q_in carry a sample this cycle
//   z_i_in      I sample, signed Q8.8
//   z_q_in      Q sample, signed Q8.8
//   pwr_out     mean power of the last completed window, unsigned Q16.16
//   pwr_valid   one-cycle pulse when pwr_out updates
//   over        last window mean > HI_TH
//   under       last window mean < LO_TH
//   lock_state  SEARCH=0, ACQ=1, LOCKED=2, HOLD=3
//   locked      high in LOCKED or HOLD
// -----------------------------------------------------------------------------
module agc_level_monitor #(
    parameter int unsigned WIN_LOG2   = 4,
    parameter logic [31:0] LO_TH      = 32'h0000_C000,
    parameter logic [31:0] HI_TH      = 32'h0001_4000,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic signed [15:0] z_i_in,
    input  logic signed [15:0] z_q_in,
    output logic [31:0]        pwr_out,
    output logic               pwr_valid,
    output logic               over,
    output logic               under,
    output logic [1:0]         lock_state,
    output logic               locked
);

    // 32 bits of sample power plus WIN_LOG2 bits of headroom: a full window
    // of maximum-power samples cannot overflow the accumulator.
    localparam int ACC_W = 32 + WIN_LOG2;
    localparam int GW    = $clog2(LOCK_CNT + 1);
    localparam int BW    = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10,
        HOLD   = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: instantaneous power
    // ------------------------------------------------------------------
    logic signed [31:0] sq_i;
    logic signed [31:0] sq_q;
    logic [31:0]        p_next;

    assign sq_i = 32'(z_i_in) * 32'(z_i_in);
    assign sq_q = 32'(z_q_in) * 32'(z_q_in);
    // Each square is at most 2^30, so the sum is at most 2^31 and is exact
    // when read as unsigned even though it can set bit 31.
    assign p_next = unsigned'(sq_i) + unsigned'(sq_q);

    logic [31:0]         p_reg;
    logic                p_vld_reg;

    // ------------------------------------------------------------------
    // Stage 2: window accumulation
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]    acc_reg;
    logic [WIN_LOG2-1:0] cnt_reg;
    logic [ACC_W-1:0]    acc_sum;
    logic [31:0]         win_mean;
    logic                win_done;
    logic                over_next;
    logic                under_next;
    logic                in_band;

    logic [31:0]         pwr_reg;
    logic                pwr_valid_reg;
    logic                over_reg;
    logic                under_reg;

    assign acc_sum    = acc_reg + ACC_W'(p_reg);
    assign win_mean   = acc_sum[ACC_W-1:WIN_LOG2];
    // A window completing in a clr cycle is discarded, so it never
    // reaches the FSM either.
    assign win_done   = p_vld_reg && (cnt_reg == '1) && !clr;
    assign over_next  = win_mean > HI_TH;
    assign under_next = win_mean < LO_TH;
    assign in_band    = !over_next && !under_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_reg         <= '0;
            p_vld_reg     <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            pwr_reg       <= '0;
            pwr_valid_reg <= 1'b0;
            over_reg      <= 1'b0;
            under_reg     <= 1'b0;
        end else if (clr) begin
            p_vld_reg     <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            pwr_valid_reg <= 1'b0;
        end else begin
            p_vld_reg     <= in_valid;
            if (in_valid) begin
                p_reg <= p_next;
            end
            pwr_valid_reg <= 1'b0;
            if (p_vld_reg) begin
                if (cnt_reg == '1) begin
                    acc_reg       <= '0;
                    cnt_reg       <= '0;
                    pwr_reg       <= win_mean;
                    pwr_valid_reg <= 1'b1;
                    over_reg      <= over_next;
                    under_reg     <= under_next;
                end else begin
                    acc_reg <= acc_sum;
                    cnt_reg <= cnt_reg + WIN_LOG2'(1);
                end
            end
        end
    end

    assign pwr_out   = pwr_reg;
    assign pwr_valid = pwr_valid_reg;
    assign over      = over_reg;
    assign under     = under_reg;

    // ------------------------------------------------------------------
    // Lock FSM: steps only on window completion
    // ------------------------------------------------------------------
    state_t        state_reg;
    state_t        state_next;
    logic [GW-1:0] gcnt_reg;
    logic [GW-1:0] gcnt_next;
    logic [BW-1:0] bcnt_reg;
    logic [BW-1:0] bcnt_next;
    logic [GW-1:0] gcnt_inc;
    logic [BW-1:0] bcnt_inc;

    assign gcnt_inc = gcnt_reg + GW'(1);
    assign bcnt_inc = bcnt_reg + BW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= SEARCH;
            gcnt_reg  <= '0;
            bcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gcnt_reg  <= gcnt_next;
            bcnt_reg  <= bcnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        gcnt_next  = gcnt_reg;
        bcnt_next  = bcnt_reg;
        if (win_done) begin
            case (state_reg)
                SEARCH: begin
                    if (in_band) begin
                        if (LOCK_CNT == 1) begin
                            state_next = LOCKED;
                        end else begin
                            state_next = ACQ;
                            gcnt_next  = GW'(1);
                        end
                    end
                end
                ACQ: begin
                    if (in_band) begin
                        if (gcnt_inc == GW'(LOCK_CNT)) begin
                            state_next = LOCKED;
                            gcnt_next  = '0;
                        end else begin
                            gcnt_next  = gcnt_inc;
                        end
                    end else begin
                        state_next = SEARCH;
                        gcnt_next  = '0;
                    end
                end
                LOCKED: begin
                    if (!in_band) begin
                        if (UNLOCK_CNT == 1) begin
                            state_next = SEARCH;
                        end else begin
                            state_next = HOLD;
                            bcnt_next  = BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (in_band) begin
                        state_next = LOCKED;
                        bcnt_next  = '0;
                    end else if (bcnt_inc == BW'(UNLOCK_CNT)) begin
                        state_next = SEARCH;
                        bcnt_next  = '0;
                    end else begin
                        bcnt_next  = bcnt_inc;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    gcnt_next  = '0;
                    bcnt_next  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        lock_state = state_reg;
        locked     = (state_reg == LOCKED) || (state_reg == HOLD);
    end

endmodule

// File: tb/tb_agc_level_monitor.sv
// -----------------------------------------------------------------------------
// tb_agc_level_monitor
//
// Self-checking bench for agc_level_monitor. A reference model tracks the
// accepted sample powers in a queue, averages each full window with plain
// integer arithmetic and tracks lock status as in-band / out-of-band run
// lengths. Directed scenarios cover lock, unlock, HOLD recovery, extreme
// values with gaps, reset/clear mid-window and the exact band edges; a
// randomized phase follows. Every cycle the DUT outputs are compared with
// the model one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_agc_level_monitor;

    localparam int          WIN      = 16;
    localparam longint      LO       = 64'h0000_C000;
    localparam longint      HI       = 64'h0001_4000;
    localparam int          LOCK_N   = 3;
    localparam int          UNLOCK_N = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic signed [15:0] z_i;
    logic signed [15:0] z_q;
    logic [31:0]        pwr_out;
    logic               pwr_valid;
    logic               over;
    logic               under;
    logic [1:0]         lock_state;
    logic               locked;

    always #5 clk = ~clk;

    agc_level_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .z_i_in     (z_i),
        .z_q_in     (z_q),
        .pwr_out    (pwr_out),
        .pwr_valid  (pwr_valid),
        .over       (over),
        .under      (under),
        .lock_state (lock_state),
        .locked     (locked)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int windows  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint win_q[$];
    bit     pend;
    longint pend_p;
    longint m_pwr;
    bit     m_pv;
    bit     m_over;
    bit     m_under;
    bit     m_locked;
    int     good_run;
    int     bad_run;

    function automatic int exp_state();
        if (!m_locked) return (good_run == 0) ? 0 : 1;
        return (bad_run == 0) ? 2 : 3;
    endfunction

    function automatic longint power(input logic signed [15:0] i, input logic signed [15:0] q);
        longint li;
        longint lq;
        li = i;
        lq = q;
        return li * li + lq * lq;
    endfunction

    task automatic model_edge(input bit r, input bit c, input bit v,
                              input logic signed [15:0] i, input logic signed [15:0] q);
        longint sum;
        longint mean;
        m_pv = 1'b0;
        if (!r) begin
            win_q.delete();
            pend     = 1'b0;
            m_pwr    = 0;
            m_over   = 1'b0;
            m_under  = 1'b0;
            m_locked = 1'b0;
            good_run = 0;
            bad_run  = 0;
        end else if (c) begin
            win_q.delete();
            pend = 1'b0;
        end else begin
            // a sample accepted on one edge is accounted for on the next
            if (pend) begin
                win_q.push_back(pend_p);
                if (win_q.size() == WIN) begin
                    sum = 0;
                    foreach (win_q[k]) sum += win_q[k];
                    win_q.delete();
                    mean    = sum / WIN;
                    m_pwr   = mean;
                    m_pv    = 1'b1;
                    m_over  = mean > HI;
                    m_under = mean < LO;
                    if (!m_over && !m_under) begin
                        bad_run = 0;
                        good_run++;
                        if (!m_locked && good_run >= LOCK_N) begin
                            m_locked = 1'b1;
                            good_run = 0;
                        end
                    end else begin
                        good_run = 0;
                        bad_run++;
                        if (m_locked && bad_run >= UNLOCK_N) begin
                            m_locked = 1'b0;
                            bad_run  = 0;
                        end
                    end
                end
            end
            pend   = v;
            pend_p = power(i, q);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step(input bit r, input bit c, input bit v,
                        input logic signed [15:0] i, input logic signed [15:0] q);
        rst      = r;
        clr      = c;
        in_valid = v;
        z_i      = i;
        z_q      = q;
        @(posedge clk);
        #1;
        model_edge(r, c, v, i, q);
        check("pwr_valid", pwr_valid, m_pv);
        check("pwr_out", pwr_out, m_pwr);
        check("over", over, m_over);
        check("under", under, m_under);
        check("lock_state", lock_state, exp_state());
        check("locked", locked, m_locked);
        if (pwr_valid) begin
            pulses++;
            windows++;
            $display("window %0d: pwr_out=%08h over=%0b under=%0b lock_state=%0d locked=%0b",
                     windows, pwr_out, over, under, lock_state, locked);
        end
    endtask

    task automatic samples(input int n, input logic signed [15:0] i, input logic signed [15:0] q);
        repeat (n) step(1'b1, 1'b0, 1'b1, i, q);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
    endtask

    logic signed [15:0] ri;
    logic signed [15:0] rq;
    int                 mode;
    bit                 rv;
    bit                 rc;
    bit                 rr;
    int                 saved_state;

    initial begin
        pend = 1'b0; pend_p = 0; m_pwr = 0; m_pv = 1'b0; m_over = 1'b0;
        m_under = 1'b0; m_locked = 1'b0; good_run = 0; bad_run = 0;

        // Reset state
        do_reset();
        do_reset();
        check("reset_pwr_out", pwr_out, 64'h0);
        check("reset_state", lock_state, 64'h0);

        // Lock acquisition: 48 samples of 1.0
        pulses = 0;
        samples(48, 16'sh0100, 16'sh0000);
        idle(1);
        check("lock_locked_e2", locked, 64'h1);
        idle(1);
        check("lock_pulses", pulses, 64'd3);
        check("lock_pwr", pwr_out, 64'h0001_0000);
        check("lock_state_final", lock_state, 64'h2);

        // Unlock: 2.0 amplitude -> mean 4.0
        samples(16, 16'sh0200, 16'sh0000);
        idle(2);
        check("unlock_hold", lock_state, 64'h3);
        check("unlock_over", over, 64'h1);
        samples(16, 16'sh0200, 16'sh0000);
        idle(2);
        check("unlock_pwr", pwr_out, 64'h0004_0000);
        check("unlock_search", lock_state, 64'h0);
        check("unlock_locked", locked, 64'h0);

        // Recovery from HOLD
        samples(48, 16'sh0100, 16'sh0000);
        idle(2);
        samples(16, 16'sh0080, 16'sh0000);
        idle(2);
        check("hold_pwr", pwr_out, 64'h0000_4000);
        check("hold_under", under, 64'h1);
        check("hold_state", lock_state, 64'h3);
        check("hold_locked", locked, 64'h1);
        samples(16, 16'sh0100, 16'sh0000);
        idle(2);
        check("recover_state", lock_state, 64'h2);

        // Extreme values, in_valid toggling
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 1'b1, 16'sh8000, 16'sh8000);
            step(1'b1, 1'b0, 1'b0, 16'sh0000, 16'sh0000);
        end
        idle(2);
        check("extreme_pulses", pulses, 64'd1);
        check("extreme_pwr", pwr_out, 64'h8000_0000);
        check("extreme_over", over, 64'h1);

        // Reset mid-window
        samples(10, 16'sh0100, 16'sh0000);
        do_reset();
        pulses = 0;
        samples(16, 16'sh0100, 16'sh0000);
        idle(2);
        check("rst_mid_pulses", pulses, 64'd1);
        check("rst_mid_pwr", pwr_out, 64'h0001_0000);

        // Clear together with the 16th sample
        samples(10, 16'sh0100, 16'sh0000);
        do_reset();
        pulses = 0;
        samples(15, 16'sh0100, 16'sh0000);
        saved_state = exp_state();
        step(1'b1, 1'b1, 1'b1, 16'sh0100, 16'sh0000);
        idle(3);
        check("clr_pulses", pulses, 64'd0);
        check("clr_pwr_kept", pwr_out, 64'h0);
        check("clr_state_kept", lock_state, 64'(saved_state));

        // Band edges: exactly LO (in band), just below LO, exactly HI, just above HI
        for (int k = 0; k < 16; k++) begin
            if (k < 8) step(1'b1, 1'b0, 1'b1, 16'sh0100, 16'sh0000);
            else       step(1'b1, 1'b0, 1'b1, 16'sh0080, 16'sh0080);
        end
        idle(2);
        check("edge_lo_pwr", pwr_out, 64'h0000_C000);
        check("edge_lo_under", under, 64'h0);
        for (int k = 0; k < 16; k++) begin
            if (k < 8)       step(1'b1, 1'b0, 1'b1, 16'sh0100, 16'sh0000);
            else if (k < 15) step(1'b1, 1'b0, 1'b1, 16'sh0080, 16'sh0080);
            else             step(1'b1, 1'b0, 1'b1, 16'sd181, 16'sh0000);
        end
        idle(2);
        check("edge_below_pwr", pwr_out, 64'h0000_BFFF);
        check("edge_below_under", under, 64'h1);
        samples(16, 16'sh0100, 16'sh0080);
        idle(2);
        check("edge_hi_pwr", pwr_out, 64'h0001_4000);
        check("edge_hi_over", over, 64'h0);
        samples(15, 16'sh0100, 16'sh0080);
        samples(1, 16'sd240, 16'sd156);
        idle(2);
        check("edge_above_pwr", pwr_out, 64'h0001_4001);
        check("edge_above_over", over, 64'h1);

        // Randomized phase
        for (int w = 0; w < 120; w++) begin
            mode = $urandom_range(0, 4);
            for (int k = 0; k < 20; k++) begin
                rv = ($urandom_range(0, 3) != 0);
                rc = ($urandom_range(0, 299) == 0);
                rr = ($urandom_range(0, 599) != 0);
                case (mode)
                    0: begin
                        ri = 16'(256 + int'($urandom_range(0, 30)) - 15);
                        rq = 16'(int'($urandom_range(0, 60)) - 30);
                    end
                    1: begin
                        ri = 16'(512 + int'($urandom_range(0, 40)) - 20);
                        rq = 16'(int'($urandom_range(0, 60)) - 30);
                    end
                    2: begin
                        ri = 16'(128 + int'($urandom_range(0, 20)) - 10);
                        rq = 16'(int'($urandom_range(0, 20)) - 10);
                    end
                    3: begin
                        ri = 16'($urandom);
                        rq = 16'($urandom);
                    end
                    default: begin
                        if ($urandom_range(0, 1) == 0) ri = 16'(int'($urandom_range(215, 228)));
                        else                           ri = 16'(int'($urandom_range(280, 292)));
                        rq = 16'sd0;
                    end
                endcase
                step(rr, rc, rv, ri, rq);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
